// File: rtl/commit_regfile_if.sv
// Commit bus between writeback and the architectural register file.
// The writeback stage is the master; commit_regfile is the slave and
// returns commit_ready.
interface commit_regfile_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [63:0] commit_pc;
  logic        commit_wen;
  logic [4:0]  commit_waddr;
  logic [63:0] commit_wdata;
  logic        commit_ebreak;

  modport master (
    output commit_valid,
    output commit_pc,
    output commit_wen,
    output commit_waddr,
    output commit_wdata,
    output commit_ebreak,
    input  commit_ready
  );

  modport slave (
    input  commit_valid,
    input  commit_pc,
    input  commit_wen,
    input  commit_waddr,
    input  commit_wdata,
    input  commit_ebreak,
    output commit_ready
  );
endinterface

// File: rtl/commit_regfile.sv
// Architectural register file and commit/halt sequencer for the NPC core.
// One retired instruction per cycle updates the GPRs, the committed PC and the
// retirement counter. An accepted ebreak halts after a one-cycle settle state.
// A no-commit watchdog forces a halt with an all-ones halt code.
module commit_regfile #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned WDOG_CYCLES = 32'd4096
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_regfile_if.slave        cbus,
  input  logic [4:0]             raddr1,
  input  logic [4:0]             raddr2,
  output logic [63:0]            rdata1,
  output logic [63:0]            rdata2,
  output logic                   is_break,
  output logic [63:0]            pc,
  output logic [63:0]            rf_0,
  output logic [63:0]            rf_1,
  output logic [63:0]            rf_2,
  output logic [63:0]            rf_3,
  output logic [63:0]            rf_4,
  output logic [63:0]            rf_5,
  output logic [63:0]            rf_6,
  output logic [63:0]            rf_7,
  output logic [63:0]            rf_8,
  output logic [63:0]            rf_9,
  output logic [63:0]            rf_10,
  output logic [63:0]            rf_11,
  output logic [63:0]            rf_12,
  output logic [63:0]            rf_13,
  output logic [63:0]            rf_14,
  output logic [63:0]            rf_15,
  output logic [63:0]            rf_16,
  output logic [63:0]            rf_17,
  output logic [63:0]            rf_18,
  output logic [63:0]            rf_19,
  output logic [63:0]            rf_20,
  output logic [63:0]            rf_21,
  output logic [63:0]            rf_22,
  output logic [63:0]            rf_23,
  output logic [63:0]            rf_24,
  output logic [63:0]            rf_25,
  output logic [63:0]            rf_26,
  output logic [63:0]            rf_27,
  output logic [63:0]            rf_28,
  output logic [63:0]            rf_29,
  output logic [63:0]            rf_30,
  output logic [63:0]            rf_31,
  output logic [63:0]            retire_cnt,
  output logic [63:0]            halt_code,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  // A zero cycle budget disables the watchdog; the compare value is then unused.
  localparam logic        WDOG_EN   = (WDOG_CYCLES != 32'd0);
  localparam logic [31:0] WDOG_LAST = WDOG_EN ? 32'(WDOG_CYCLES - 32'd1) : 32'd0;

  state_t      state_q, state_d;
  logic [31:0] idle_q, idle_d;
  logic [63:0] rf_q [32];
  logic [63:0] pc_q;
  logic [63:0] cnt_q;
  logic [63:0] code_q;
  logic        break_q;
  logic        timeout_q;

  logic        ready;
  logic        acc;
  logic        rf_we;
  logic        wdog_exp;
  logic        pend_done;
  logic        wdog_halt;

  // Ready depends on state only, never on commit_valid.
  assign ready             = (state_q == ST_RUN);
  assign cbus.commit_ready = ready;
  assign acc               = cbus.commit_valid & ready;

  // ebreak never writes a GPR, and x0 is hard-wired to zero.
  assign rf_we    = acc & cbus.commit_wen & ~cbus.commit_ebreak &
                    (cbus.commit_waddr != 5'd0);
  // A commit in the expiry cycle wins over the watchdog.
  assign wdog_exp = WDOG_EN & (idle_q == WDOG_LAST) & ~acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and halt-event strobes.
  always_comb begin
    state_d   = state_q;
    pend_done = 1'b0;
    wdog_halt = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (acc && cbus.commit_ebreak) begin
          state_d = ST_HALT_PEND;
        end else if (wdog_exp) begin
          state_d   = ST_HALTED;
          wdog_halt = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT_PEND: begin
        state_d   = ST_HALTED;
        pend_done = 1'b1;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // Idle counter: counts commit-less cycles while running, frozen otherwise.
  always_comb begin
    idle_d = idle_q;
    if (state_q == ST_RUN) begin
      if (acc) begin
        idle_d = 32'd0;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end else begin
      idle_d = idle_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= 32'd0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // GPR array; entry 0 is cleared by reset and never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 64'd0;
      end
    end else if (rf_we) begin
      rf_q[cbus.commit_waddr] <= cbus.commit_wdata;
    end
  end

  // Committed PC and retirement counter advance on every accepted commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= 64'd0;
    end else if (acc) begin
      pc_q  <= cbus.commit_pc;
      cnt_q <= cnt_q + 64'd1;
    end
  end

  // Halt status: a0 on an ebreak halt, all-ones plus timeout on a watchdog halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      break_q   <= 1'b0;
      timeout_q <= 1'b0;
      code_q    <= 64'd0;
    end else if (pend_done) begin
      break_q <= 1'b1;
      code_q  <= rf_q[10];
    end else if (wdog_halt) begin
      break_q   <= 1'b1;
      timeout_q <= 1'b1;
      code_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
    end
  end

  // Read ports with write-through bypass of the commit being accepted this cycle.
  always_comb begin
    rdata1 = rf_q[raddr1];
    rdata2 = rf_q[raddr2];
    if (rf_we && (raddr1 == cbus.commit_waddr)) begin
      rdata1 = cbus.commit_wdata;
    end else begin
      rdata1 = rf_q[raddr1];
    end
    if (rf_we && (raddr2 == cbus.commit_waddr)) begin
      rdata2 = cbus.commit_wdata;
    end else begin
      rdata2 = rf_q[raddr2];
    end
  end

  assign is_break   = break_q;
  assign pc         = pc_q;
  assign retire_cnt = cnt_q;
  assign halt_code  = code_q;
  assign timeout    = timeout_q;

  assign rf_0  = 64'd0;
  assign rf_1  = rf_q[1];
  assign rf_2  = rf_q[2];
  assign rf_3  = rf_q[3];
  assign rf_4  = rf_q[4];
  assign rf_5  = rf_q[5];
  assign rf_6  = rf_q[6];
  assign rf_7  = rf_q[7];
  assign rf_8  = rf_q[8];
  assign rf_9  = rf_q[9];
  assign rf_10 = rf_q[10];
  assign rf_11 = rf_q[11];
  assign rf_12 = rf_q[12];
  assign rf_13 = rf_q[13];
  assign rf_14 = rf_q[14];
  assign rf_15 = rf_q[15];
  assign rf_16 = rf_q[16];
  assign rf_17 = rf_q[17];
  assign rf_18 = rf_q[18];
  assign rf_19 = rf_q[19];
  assign rf_20 = rf_q[20];
  assign rf_21 = rf_q[21];
  assign rf_22 = rf_q[22];
  assign rf_23 = rf_q[23];
  assign rf_24 = rf_q[24];
  assign rf_25 = rf_q[25];
  assign rf_26 = rf_q[26];
  assign rf_27 = rf_q[27];
  assign rf_28 = rf_q[28];
  assign rf_29 = rf_q[29];
  assign rf_30 = rf_q[30];
  assign rf_31 = rf_q[31];

endmodule

// File: doc/commit_regfile.md
# commit_regfile

Architectural register file and commit/halt sequencer for the NPC core. Accepts one retired instruction per cycle from writeback, updates the 32×64 GPRs and the committed PC, and counts retirements. It drives `is_break`, `pc` and `rf_0`..`rf_31` directly into the DPI simulation model. It also provides two read ports to decode and a no-commit watchdog that forces a halt.

## Interface
Clock is `clk`; reset is `rst`, synchronous, active-high.

Parameters:
- `RESET_PC`, 64'h8000_0000: value held on `pc` out of reset.
- `WDOG_CYCLES`, 4096: consecutive commit-less RUN cycles before a forced halt; 0 disables the watchdog.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous active-high reset
- `raddr1`, `raddr2`  in  5  read addresses (decode)
- `rdata1`, `rdata2`  out  64  combinational read data
- `commit_valid`  in  1  a retired instruction is presented
- `commit_ready`  out  1  block accepts commits; high only in RUN
- `commit_pc`  in  64  PC of the retiring instruction
- `commit_wen`  in  1  retiring instruction writes a GPR
- `commit_waddr`  in  5  destination register
- `commit_wdata`  in  64  destination value
- `commit_ebreak`  in  1  retiring instruction is `ebreak`
- `is_break`  out  1  simulation halt request to the DPI model
- `pc`  out  64  PC of the last accepted commit
- `rf_0` .. `rf_31`  out  64 each  architectural GPR values, registered
- `retire_cnt`  out  64  accepted-commit count
- `halt_code`  out  64  `a0` (`rf_10`) latched at halt; all-ones on watchdog halt
- `timeout`  out  1  halt was caused by the watchdog

## Operation
- **Accept condition.** `acc = commit_valid & commit_ready`. No commit is accepted in any other cycle; `commit_*` inputs are ignored while `commit_ready` is 0.
- **States:**
  - RUN: `commit_ready` = 1.
  - HALT_PEND: one settle cycle, `commit_ready` = 0.
  - HALTED: terminal until `rst`, `commit_ready` = 0.
- **Transitions:**
  - RUN → HALT_PEND when `acc & commit_ebreak`.
  - HALT_PEND → HALTED unconditionally.
  - RUN → HALTED on watchdog expiry.
  - HALTED → HALTED until reset.
- **On `acc`:**
  - `pc` ← `commit_pc`.
  - `retire_cnt` ← `retire_cnt` + 1, wrapping modulo 2^64.
  - If `commit_wen & ~commit_ebreak & (commit_waddr != 0)`: `rf[commit_waddr]` ← `commit_wdata`.
- **x0.** `rf_0` is constant 0. Writes to x0 are discarded, and reads of x0 return 0.
- **Read ports.** `rdataN = (raddrN != 0 && acc && commit_wen && !commit_ebreak && commit_waddr == raddrN) ? commit_wdata : rf[raddrN]`. This is write-through bypass; both ports may hit the same register.
- **Entering HALTED via HALT_PEND.** `is_break` ← 1, `halt_code` ← `rf_10`, `timeout` stays 0.
- **Watchdog.**
  - A 32-bit counter `idle` runs only in RUN.
  - `acc` clears it to 0; otherwise it increments.
  - If `WDOG_CYCLES != 0`, `idle == WDOG_CYCLES-1` and no `acc` this cycle: go to HALTED with `is_break` ← 1, `timeout` ← 1, `halt_code` ← 64'hFFFF_FFFF_FFFF_FFFF.
  - An `acc` in the same cycle as expiry wins: the commit is accepted and `idle` clears.
- **Reset values.**
  - `rf_0`..`rf_31` = 0, `pc` = `RESET_PC`.
  - `retire_cnt`, `halt_code`, `idle` = 0; `is_break`, `timeout` = 0.
  - State = RUN, so `commit_ready` = 1 from the first post-reset cycle.
- **Reset mid-operation.** `rst` overrides everything at the next edge, including in HALTED and HALT_PEND. An `acc` coincident with `rst` has no effect.

## Timing
- Write at edge N is visible on `rf_*` and on non-bypassed `rdata` after edge N. The bypass makes it visible combinationally during cycle N.
- `pc` and `retire_cnt` update at the accepting edge.
- `ebreak` accepted at edge N:
  - After N: state HALT_PEND, `commit_ready` = 0, `is_break` = 0, final `pc`/`rf_*` stable.
  - After N+1: `is_break` = 1 and `halt_code` are valid.
  - `is_break` stays 1 until reset.
- Watchdog: with no `acc` since edge M, `is_break` rises after edge M+`WDOG_CYCLES`.
- Throughput is one commit per cycle in RUN. `commit_ready` is combinational from state only, with no dependence on `commit_valid`.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` 2 cycles, then release.
  - Required: `pc`=0x8000_0000; all `rf_*`, `retire_cnt`, `is_break`, `timeout` = 0; `commit_ready`=1.
- **Writes, x0 and bypass:**
  - Stimulus: commit x5←0x1234 with `raddr1`=5 in the same cycle, then commit x0←0xFFFF.
  - Required: `rdata1`=0x1234 combinationally; `rf_5`=0x1234 next cycle; `rf_0` stays 0; `retire_cnt`=2.
- **Ebreak halt:**
  - Stimulus: commit x10←42, then `ebreak` at pc 0x8000_0008 with `commit_wen`=1, `waddr`=3.
  - Required: x3 unchanged; `pc`=0x8000_0008; `is_break`=0 for one cycle, then 1 with `halt_code`=42 and `timeout`=0.
  - Required: commits presented afterwards are ignored and `retire_cnt` stays at 2.
- **Watchdog:**
  - Stimulus: `WDOG_CYCLES`=8, no commits after reset.
  - Required: `is_break`=1, `timeout`=1, `halt_code`=all-ones after the 8th edge.
  - Stimulus: repeat with a commit at idle=7.
  - Required: no halt.
- **Reset from HALTED:**
  - Stimulus: assert `rst` for 1 cycle after an ebreak halt.
  - Required: state RUN, `is_break`=0, `rf_*`=0, `pc`=`RESET_PC`; the next commit is accepted.
